// File: rtl/ra_pq.sv
// Register-array priority queue: unsorted compacted slot array with a combinational min-search tree.
// Optional sticky overflow flag and empty-dequeue assertion enabled by defining RA_PQ_OVF_EN.

package pq_pkg;
   parameter int KEY_WIDTH = 8;
   parameter int VAL_WIDTH = 8;
endpackage

module ra_pq #(
   parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
   parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
   parameter int DEPTH     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enq,
   input  logic                           deq,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
   output logic                           empty,
   output logic                           full,
   output logic                           ovf
);

   localparam int W  = KEY_WIDTH + VAL_WIDTH;
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int P  = 1 << IW;

   logic [W-1:0]         slot [DEPTH];
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_nxt;
   logic [CW-1:0]        count_m1;
   logic [IW-1:0]        min_idx;
   logic [IW-1:0]        wr_idx;
   logic [IW-1:0]        last_idx;
   logic                 do_deq;

   logic [KEY_WIDTH-1:0] nk [2*P];
   logic [IW-1:0]        ni [2*P];
   logic                 nv [2*P];
   logic                 take_r;

   // Heap-indexed tournament: leaves at P..2P-1, left child always covers lower
   // slot indices, so picking right only on strictly-less keeps FIFO order for ties.
   always_comb begin
      take_r = 1'b0;
      for (int i = 0; i < 2*P; i++) begin
         nk[i] = '0;
         ni[i] = '0;
         nv[i] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         nk[P+i] = slot[i][W-1:VAL_WIDTH];
         ni[P+i] = IW'(i);
         nv[P+i] = (CW'(i) < count);
      end
      for (int i = P-1; i >= 1; i--) begin
         take_r = nv[2*i+1] && (!nv[2*i] || (nk[2*i+1] < nk[2*i]));
         nk[i]  = take_r ? nk[2*i+1] : nk[2*i];
         ni[i]  = take_r ? ni[2*i+1] : ni[2*i];
         nv[i]  = nv[2*i] || nv[2*i+1];
      end
   end

   assign min_idx  = ni[1];
   assign count_m1 = count - CW'(1);
   assign wr_idx   = count[IW-1:0];
   assign last_idx = count_m1[IW-1:0];
   assign do_deq   = deq && !empty;
   assign kvo      = empty ? '0 : slot[min_idx];

   always_comb begin
      count_nxt = count;
      if (do_deq && !enq)
         count_nxt = count_m1;
      else if (!do_deq && enq && !full)
         count_nxt = count + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

   // Removal compacts everything above the minimum down one; a replace then
   // refills the freed top slot, so the array stays dense and age-ordered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (do_deq) begin
            for (int i = 0; i < DEPTH-1; i++) begin
               if (IW'(i) >= min_idx)
                  slot[i] <= slot[i+1];
            end
            if (enq)
               slot[last_idx] <= kvi;
         end else if (enq && !full) begin
            slot[wr_idx] <= kvi;
         end
      end
   end

`ifdef RA_PQ_OVF_EN
   logic ovf_r;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_r <= 1'b0;
      else if (enq && !deq && full)
         ovf_r <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(deq && !enq && empty));
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ra_pq.sv
// Self-checking bench for ra_pq (DEPTH=4, 8-bit key/val): queue-based reference model
// checked every cycle, plus directed literal checks. Honours RA_PQ_OVF_EN.

module tb_ra_pq;

   logic        clk;
   logic        rst;
   logic        enq;
   logic        deq;
   logic [15:0] kvi;
   logic [15:0] kvo;
   logic        empty;
   logic        full;
   logic        ovf;

   int          total;
   int          bad;
   bit          checking;

   logic [15:0] mq [$];
   logic        movf;

   ra_pq #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .enq   (enq),
      .deq   (deq),
      .kvi   (kvi),
      .kvo   (kvo),
      .empty (empty),
      .full  (full),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int modelMin();
      int m = 0;
      for (int i = 1; i < mq.size(); i++)
         if (mq[i][15:8] < mq[m][15:8]) m = i;
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic d, input logic [15:0] kv);
      rst = r;
      enq = e;
      deq = d;
      kvi = kv;
      @(posedge clk);
      #1;
   endtask

   // Reference model: insertion-ordered list, min = first entry with smallest key
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         movf = 1'b0;
      end else if (deq && mq.size() > 0) begin
         mq.delete(modelMin());
         if (enq) mq.push_back(kvi);
      end else if (enq) begin
         if (mq.size() < 4)
            mq.push_back(kvi);
`ifdef RA_PQ_OVF_EN
         else if (!deq)
            movf = 1'b1;
`endif
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         checkOutput("kvo",   kvo, (mq.size() == 0) ? 16'h0 : mq[modelMin()]);
         checkOutput("empty", 16'(empty), 16'(mq.size() == 0));
         checkOutput("full",  16'(full),  16'(mq.size() == 4));
         checkOutput("ovf",   16'(ovf),   16'(movf));
      end
   end

   initial begin
      logic        r, e, d;
      logic [15:0] kv;
      logic        exp_ovf;
      total    = 0;
      bad      = 0;
      checking = 1'b0;
      movf     = 1'b0;
      rst = 1'b1; enq = 1'b0; deq = 1'b0; kvi = '0;
`ifdef RA_PQ_OVF_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif

      applyStimulus(1, 0, 0, 16'h0);
      checking = 1'b1;
      checkOutput("lit_rst_kvo",   kvo,        16'h0);
      checkOutput("lit_rst_empty", 16'(empty), 16'd1);
      checkOutput("lit_rst_full",  16'(full),  16'd0);
      checkOutput("lit_rst_ovf",   16'(ovf),   16'd0);
      applyStimulus(1, 1, 0, 16'h0505);
      checkOutput("lit_rst_enq_empty", 16'(empty), 16'd1);

      applyStimulus(0, 1, 0, 16'h080E);
      checkOutput("lit_enq_kvo", kvo, 16'h080E);
      applyStimulus(0, 1, 1, 16'h020C);
      checkOutput("lit_repl_kvo", kvo, 16'h020C);
      checkOutput("lit_repl_empty", 16'(empty), 16'd0);

      applyStimulus(0, 1, 0, 16'h090A);
      applyStimulus(0, 1, 0, 16'h090B);
      applyStimulus(0, 1, 0, 16'h090C);
      checkOutput("lit_full", 16'(full), 16'd1);
      checkOutput("lit_fifo0", kvo, 16'h020C);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_fifo1", kvo, 16'h090A);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_fifo2", kvo, 16'h090B);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_fifo3", kvo, 16'h090C);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_drain_empty", 16'(empty), 16'd1);
      checkOutput("lit_drain_kvo", kvo, 16'h0);

      applyStimulus(0, 1, 0, 16'h0301);
      applyStimulus(0, 1, 0, 16'h0402);
      applyStimulus(0, 1, 0, 16'h0503);
      applyStimulus(0, 1, 0, 16'h0604);
      applyStimulus(0, 1, 0, 16'h010B);
      checkOutput("lit_drop_kvo",  kvo,       16'h0301);
      checkOutput("lit_drop_full", 16'(full), 16'd1);
      checkOutput("lit_drop_ovf",  16'(ovf),  16'(exp_ovf));
      applyStimulus(0, 1, 1, 16'h010B);
      checkOutput("lit_full_repl_kvo",  kvo,       16'h010B);
      checkOutput("lit_full_repl_full", 16'(full), 16'd1);

      applyStimulus(1, 0, 0, 16'h0);
      checkOutput("lit_rst_ovf_clr", 16'(ovf), 16'd0);
      applyStimulus(0, 1, 0, 16'h0501);
      applyStimulus(0, 1, 0, 16'h0302);
      applyStimulus(0, 1, 0, 16'h0703);
      checkOutput("lit_il_min", kvo, 16'h0302);
      applyStimulus(0, 0, 1, 16'h0);
      applyStimulus(0, 1, 0, 16'h0404);
      checkOutput("lit_il_d0", kvo, 16'h0404);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_il_d1", kvo, 16'h0501);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_il_d2", kvo, 16'h0703);
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_il_empty", 16'(empty), 16'd1);

`ifndef RA_PQ_OVF_EN
      applyStimulus(0, 0, 1, 16'h0);
      checkOutput("lit_deq_empty", 16'(empty), 16'd1);
`endif
      applyStimulus(0, 1, 1, 16'h0B01);
      checkOutput("lit_ed_empty_kvo",   kvo,        16'h0B01);
      checkOutput("lit_ed_empty_empty", 16'(empty), 16'd0);
      checkOutput("lit_ed_empty_full",  16'(full),  16'd0);

      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 99) == 0);
         e  = ($urandom_range(0, 99) < 55);
         d  = ($urandom_range(0, 99) < 45);
         kv = {8'($urandom_range(0, 7)), 8'($urandom)};
`ifdef RA_PQ_OVF_EN
         if (d && !e && mq.size() == 0) d = 1'b0;
`endif
         applyStimulus(r, e, d, kv);
      end

      applyStimulus(0, 0, 0, 16'h0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ra_pq.md
# ra_pq

Register-array priority queue: the responder end of the `pq_if` enqueue/dequeue interface that the priority-queue benches drive. It stores up to `DEPTH` key/value pairs in an unsorted, compacted register array and presents the minimum-key entry on `kvo` through a combinational min-search tree. It is a drop-in alternative to the shift-register queue: same `pq_if` signal set and semantics, with a different storage/search architecture for area/timing comparison.

## Interface
- `KEY_WIDTH`, from `pq_pkg`: key width; smaller key = higher priority.
- `VAL_WIDTH`, from `pq_pkg`: payload width.
- `DEPTH`, 8: number of entries; ≥2; need not be a power of two.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enq`  in  1  insert `kvi` this cycle.
- `deq`  in  1  remove current `kvo` entry this cycle.
- `kvi`  in  KEY_WIDTH+VAL_WIDTH  `{key,val}` to insert.
- `kvo`  out  KEY_WIDTH+VAL_WIDTH  `{key,val}` of current minimum; 0 when empty.
- `empty`  out  1  count == 0 (registered).
- `full`  out  1  count == DEPTH (registered).
- `ovf`  out  1  sticky dropped-enqueue flag (see Configuration).

## Operation
- State: `slot[0..DEPTH-1]` of `{key,val}`, `count` (clog2(DEPTH+1) bits). Valid slots are always `0..count-1` (compacted); lower index = older.
- Min search: combinational tree over valid slots; strictly-less compare, ties go to lower index, so equal keys dequeue in FIFO order. Result `min_idx`. `kvo = empty ? 0 : slot[min_idx]`.
- Consumer samples `kvo` in the same cycle it asserts `deq`.
- Per cycle, effective operation (rst has priority over all):
  - `enq & !deq`: if !full, `slot[count] <= kvi`, count+1; if full, drop (count, slots unchanged; `ovf` set if enabled).
  - `deq & !enq`: if !empty, slots `min_idx+1..count-1` shift down one, count−1; if empty, ignored.
  - `enq & deq`, !empty: replace — remove min (shift-down compaction) and write `kvi` at `slot[count-1]`; count unchanged. Valid also when full.
  - `enq & deq`, empty: treated as enq only.
  - neither: hold.
- Keys compared unsigned, full KEY_WIDTH; val never participates in ordering.
- Reset: count <= 0, `ovf` <= 0; slot contents don't-care (never visible, kvo forced 0 when empty). Reset mid-operation discards all entries; enq/deq that cycle ignored.

## Timing
- Reset values: `kvo`=0, `empty`=1, `full`=0, `ovf`=0, visible the cycle after `rst` sampled high.
- Enqueue-to-visible latency: 1 cycle (kvo/empty/full reflect the insert after the edge that samples enq).
- Dequeue: kvo shows next minimum 1 cycle after the sampling edge.
- Back-to-back enq/deq every cycle supported; no stalls, no handshake beyond `empty`/`full`.
- `empty`, `full`, `ovf` are flops; `kvo` is combinational from flops (min-tree depth clog2(DEPTH) comparators).

## Configuration
- `RA_PQ_OVF_EN` defined: `ovf` goes to 1 on the first cycle an enq-only is sampled while `full`, stays 1 until `rst`; also an immediate assertion fires on deq-only while `empty`.
- Not defined: `ovf` tied to 0, no assertion logic; queue behaviour otherwise identical.

## Test plan (DEPTH=4, KEY_WIDTH=VAL_WIDTH=8)
- Reset: rst 1 cycle -> kvo=0, empty=1, full=0, ovf=0; rst with enq=1 -> still empty next cycle.
- enq(8,14); then enq&deq(2,12) -> kvo={8,14} then {2,12}, count stays 1.
- From {2,12}: enq(9,10),(9,11),(9,12) -> full=1; 4 deqs return {2,12},{9,10},{9,11},{9,12} in order, then empty=1, kvo=0.
- Full queue + enq(1,11) alone -> dropped, kvo unchanged, ovf=1 with `RA_PQ_OVF_EN`, 0 without; then enq&deq(1,11) while full -> min removed, kvo={1,11}, full stays 1.
- Interleaved enq(5,1),enq(3,2),enq(7,3),deq,enq(4,4) -> deq returns {3,2}; remaining dequeue order {4,4},{5,1},{7,3}.
- deq on empty and enq&deq on empty with (11,1) -> first ignored; second yields kvo={11,1}, count=1.
